// File: rtl/dm_pkg.sv
// Shared definitions for the sized data memory and the load unit.
//   - size encodings for byte / half / word / reserved accesses
//   - FSM state encoding
//   - captured request record
//   - misaligned(): alignment check from size and the low address bits
package dm_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   // Request latched on acceptance; addr is already reduced modulo depth.
   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic        sign_ext;
      logic [31:0] addr;
      logic [31:0] data;
   } req_t;

   // Reserved size is treated separately by the caller.
   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
      return ((sz == SZ_HALF) && lo[0]) || ((sz == SZ_WORD) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/sized_data_memory_if.sv
// Request/response bundle between the MEM stage and the data memory.
//   master : drives dm_cs, dm_wr, dm_rd, size, sign_ext, Address, D_in
//            receives D_Out, ready, busy, acc_err
//   slave  : the memory side of the same signals
interface sized_data_memory_if;
   logic        dm_cs;
   logic        dm_wr;
   logic        dm_rd;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] Address;
   logic [31:0] D_in;
   logic [31:0] D_Out;
   logic        ready;
   logic        busy;
   logic        acc_err;

   modport master (
      output dm_cs, dm_wr, dm_rd, size, sign_ext, Address, D_in,
      input  D_Out, ready, busy, acc_err
   );

   modport slave (
      input  dm_cs, dm_wr, dm_rd, size, sign_ext, Address, D_in,
      output D_Out, ready, busy, acc_err
   );
endinterface

// File: rtl/dm_read_align.sv
// Combinational load formatter.
//   size     : access size (byte / half / word)
//   sign_ext : 1 = sign-extend, 0 = zero-extend (byte/half only)
//   bytes    : fetched bytes, bytes[0] = mem[a], bytes[1] = mem[a+1], ...
//   rdata    : right-justified, extended read word (big-endian assembly)
module dm_read_align
   import dm_pkg::*;
(
   input  logic [1:0]      size,
   input  logic            sign_ext,
   input  logic [3:0][7:0] bytes,
   output logic [31:0]     rdata
);
   always_comb begin
      rdata = '0;
      case (size)
         SZ_BYTE: rdata = {{24{sign_ext & bytes[0][7]}}, bytes[0]};
         SZ_HALF: rdata = {{16{sign_ext & bytes[0][7]}}, bytes[0], bytes[1]};
         SZ_WORD: rdata = {bytes[0], bytes[1], bytes[2], bytes[3]};
         default: rdata = '0;
      endcase
   end
endmodule

// File: rtl/sized_data_memory.sv
// Byte-addressable big-endian data memory with byte/half/word accesses,
// sign/zero-extended loads, alignment checking and a wait-state FSM.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : slave side of sized_data_memory_if (request in, D_Out /
//                ready / busy / acc_err out)
// Storage is four byte lanes indexed by addr[1:0]; aligned accesses never
// cross a lane row, so every access touches a single row.
module sized_data_memory
   import dm_pkg::*;
#(
   parameter int ADDR_WIDTH  = 12,
   parameter int WAIT_STATES = 1
) (
   input logic                clk,
   input logic                reset,
   sized_data_memory_if.slave bus
);
   localparam int          ROW_W = (ADDR_WIDTH > 2) ? ADDR_WIDTH - 2 : 1;
   localparam int          ROWS  = 1 << (ADDR_WIDTH - 2);
   localparam logic [31:0] AMASK = 32'((64'd1 << ADDR_WIDTH) - 64'd1);

   state_t          state, state_n;
   logic [2:0]      cnt, cnt_n;
   logic            accept, exec, err;
   req_t            req;
   logic            ready_q, err_q;
   logic [31:0]     dout_q;
   logic [ROW_W-1:0] row;
   logic [1:0]      lo;
   logic [2:0]      nbytes;
   logic [3:0]      lane_we;
   logic [3:0][7:0] lane_wd, lane_rd, fetch;
   logic [31:0]     rdata;

   assign lo  = req.addr[1:0];
   assign row = ROW_W'(req.addr >> 2);
   assign err = (req.size == SZ_RSVD) || misaligned(req.size, lo);

   // Next-state / control
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      accept  = 1'b0;
      exec    = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.dm_cs && (bus.dm_rd || bus.dm_wr)) begin
               accept  = 1'b1;
               cnt_n   = 3'(WAIT_STATES);
               state_n = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt != 3'd0) begin
               cnt_n = cnt - 3'd1;
            end else begin
               exec    = 1'b1;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Byte i of the access (0 = most significant) lands in lane lo+i.
   always_comb begin
      nbytes  = 3'd0;
      lane_we = '0;
      lane_wd = '0;
      fetch   = '0;
      case (req.size)
         SZ_BYTE: nbytes = 3'd1;
         SZ_HALF: nbytes = 3'd2;
         SZ_WORD: nbytes = 3'd4;
         default: nbytes = 3'd0;
      endcase
      for (int i = 0; i < 4; i++) begin
         fetch[i] = lane_rd[2'(lo + 2'(i))];
         if (i < int'(nbytes)) begin
            lane_we[2'(lo + 2'(i))] = 1'b1;
            lane_wd[2'(lo + 2'(i))] = req.data[8*(int'(nbytes)-1-i) +: 8];
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_lane
      logic [7:0] mem [ROWS];
      always_ff @(posedge clk) begin
         if (!reset && exec && !err && req.wr && lane_we[g])
            mem[row] <= lane_wd[g];
      end
      assign lane_rd[g] = mem[row];
   end

   dm_read_align u_align (
      .size     (req.size),
      .sign_ext (req.sign_ext),
      .bytes    (fetch),
      .rdata    (rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         req     <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         dout_q  <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         ready_q <= exec;
         err_q   <= exec && err;
         if (accept)
            req <= '{wr: bus.dm_wr, size: bus.size, sign_ext: bus.sign_ext,
                     addr: bus.Address & AMASK, data: bus.D_in};
         if (exec && !err && !req.wr)
            dout_q <= rdata;
      end
   end

   assign bus.D_Out   = dout_q;
   assign bus.ready   = ready_q;
   assign bus.busy    = (state == S_BUSY);
   assign bus.acc_err = err_q;

endmodule

// File: doc/sized_data_memory.md
Name: sized_data_memory

Overview:
- Parametrised successor to the team's 4K x 8 big-endian data memory.
- Byte-addressable storage supporting byte, halfword and word accesses, with sign/zero extension on reads.
- Detects misaligned and illegal accesses.
- Uses a configurable wait-state FSM and a ready pulse, so the MIPS datapath can stall on memory. Sits in the MEM stage between ALU address output and writeback mux.

Parameters:
- ADDR_WIDTH, 12: byte-address bits used; depth = 2^ADDR_WIDTH bytes; must be >= 2.
- WAIT_STATES, 1: extra busy cycles per access (0..7).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- dm_cs  in  1  chip select.
- dm_wr  in  1  write request.
- dm_rd  in  1  read request.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- sign_ext  in  1  read extension: 1 sign-extend, 0 zero-extend (byte/half only).
- Address  in  32  byte address; bits above ADDR_WIDTH-1 ignored (modulo depth).
- D_in  in  32  write data, right-justified (byte D_in[7:0], half D_in[15:0]).
- D_Out  out  32  registered read data; holds last read value.
- ready  out  1  one-cycle pulse: access complete.
- busy  out  1  high while an access is in flight.
- acc_err  out  1  valid with ready: access rejected (misaligned or reserved size).

Behaviour:
- Reset: synchronous, active-high. On reset, state=IDLE, D_Out=0, ready=0, busy=0, acc_err=0, wait counter=0. Memory contents are not cleared.
- FSM states: IDLE and BUSY.
- IDLE:
  - Acceptance: a request is accepted on a rising edge when dm_cs=1 and (dm_rd|dm_wr)=1.
  - On acceptance, Address, D_in, size, sign_ext and op are captured, counter is loaded with WAIT_STATES, and state goes to BUSY.
  - If dm_rd and dm_wr are both 1, the request is a write.
- BUSY:
  - busy=1. All inputs are ignored; no second request is queued.
  - While counter != 0, counter decrements each edge.
  - On the edge with counter==0, the access executes, ready<=1, and state goes to IDLE.
- Latency: ready is high in cycle WAIT_STATES+1 after the acceptance edge.
- Back-to-back: a new request may be accepted on the edge that ends the ready cycle, i.e. while ready=1 in IDLE.
- Outputs: ready and acc_err are registered and high for exactly one cycle. acc_err=0 whenever ready=0.
- Error check (at execute):
  - Error conditions: half with A[0]=1; word with A[1:0]!=00; size=11.
  - On error, ready=1 and acc_err=1; no memory write occurs and D_Out is unchanged.
- Write, big-endian, at a = captured address modulo depth:
  - byte: mem[a]=D_in[7:0].
  - half: mem[a]=D_in[15:8], mem[a+1]=D_in[7:0].
  - word: mem[a..a+3]=D_in[31:24]..D_in[7:0].
  - D_Out is unchanged on writes.
- Read:
  - byte: {24{ext},mem[a]}.
  - half: {16{ext},mem[a],mem[a+1]}.
  - word: {mem[a],mem[a+1],mem[a+2],mem[a+3]}.
  - ext = sign_ext & MSB of the fetched field.
- Wrap: aligned accesses never cross the top of memory, since depth is a multiple of 4. Address 2^ADDR_WIDTH+k aliases k.
- Reset mid-access: the pending access is abandoned, no write commits, and ready does not pulse.
- No tri-state outputs: D_Out is always driven.

Decomposition:
- Shared package dm_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11;
  - FSM state encoding S_IDLE / S_BUSY;
  - a function computing misalignment from size and the low address bits.
- One sub-module, dm_read_align: combinational. Takes size, sign_ext and the four fetched bytes, and produces the 32-bit extended read word. It is reused later by the load unit.

Test Plan (ADDR_WIDTH=12, WAIT_STATES=1):
1. Reset; write word 0xDEADBEEF @0x010; read word @0x010 -> D_Out=0xDEADBEEF; ready 2 cycles after each acceptance; busy high for 2 cycles.
2. Byte reads @0x010: sign_ext=1 -> 0xFFFFFFDE, sign_ext=0 -> 0x000000DE. Half read @0x012, sign_ext=1 -> 0xFFFFBEEF.
3. Write half 0x8001 @0x022, then read word @0x020 -> D_Out[15:0]=0x8001. Write byte 0x7F @0x023, then read half @0x022, sign_ext=1 -> 0xFFFF807F.
4. Misaligned word write 0x12345678 @0x011 -> ready=1 with acc_err=1. Read word @0x010 still 0xDEADBEEF. size=11 read -> acc_err=1, D_Out unchanged.
5. Assert a second request while busy -> ignored, single ready pulse. Request asserted during the ready cycle -> accepted, next ready 2 cycles later.
6. Assert reset in the BUSY cycle of a write 0xCAFEF00D @0x040 -> no ready, outputs zero. Then write 0x01020304 @0x1FFC and read word @0xFFC -> 0x01020304 (alias).
